// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller around a registered-read dual-port BRAM.
// A 2-entry skid stage absorbs the one-cycle read latency so pops can stream back to back.
module bram_fifo_ctrl #(
  parameter int P_DATA_MSB    = 15,
  parameter int P_ADDRESS_MSB = 4,
  parameter int P_DEPTH       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset_sync,
  input  logic                   i_push_valid,
  output logic                   o_push_ready,
  input  logic [P_DATA_MSB:0]    i_push_data,
  output logic                   o_pop_valid,
  input  logic                   i_pop_ready,
  output logic [P_DATA_MSB:0]    o_pop_data,
  output logic [P_ADDRESS_MSB+2:0] o_count,
  output logic                   o_bram_we,
  output logic [P_ADDRESS_MSB:0] o_bram_waddr,
  output logic [P_DATA_MSB:0]    o_bram_wdata,
  output logic [P_ADDRESS_MSB:0] o_bram_raddr,
  input  logic [P_DATA_MSB:0]    i_bram_rdata
);
  localparam int AW = P_ADDRESS_MSB + 1;
  localparam int PW = AW + 1;
  localparam int CW = P_ADDRESS_MSB + 3;
  localparam int DW = P_DATA_MSB + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(P_DEPTH);

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    skid_cnt_q, skid_cnt_d;
  logic [DW-1:0] skid_q [2];
  logic [DW-1:0] skid_d [2];

  logic [PW-1:0] fill;
  logic          accept, pop, fetch;
  logic [1:0]    occ_after_pop;
  logic [2:0]    occ_next;

  // Fill uses registered pointers only, so a word is never read in its write cycle.
  assign fill          = wptr_q - rptr_q;
  assign o_push_ready  = (fill < DEPTH_P) && !i_reset_sync;
  assign accept        = i_push_valid && o_push_ready;
  assign o_pop_valid   = (skid_cnt_q != 2'd0);
  assign o_pop_data    = skid_q[0];
  assign pop           = o_pop_valid && i_pop_ready;
  assign occ_after_pop = skid_cnt_q - {1'b0, pop};
  assign occ_next      = {1'b0, skid_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign fetch         = (fill != '0) && (occ_next < 3'd2);

  assign o_bram_we    = accept;
  assign o_bram_waddr = wptr_q[AW-1:0];
  assign o_bram_wdata = i_push_data;
  assign o_bram_raddr = rptr_q[AW-1:0];
  assign o_count      = CW'(fill) + CW'(inflight_q) + CW'(skid_cnt_q);

  always_comb begin
    wptr_d     = wptr_q + PW'(accept);
    rptr_d     = rptr_q + PW'(fetch);
    inflight_d = fetch;
    skid_d     = skid_q;
    if (pop) skid_d[0] = skid_q[1];
    // Returning read data lands right behind whatever survives this cycle's pop.
    if (inflight_q) skid_d[occ_after_pop[0]] = i_bram_rdata;
    skid_cnt_d = occ_after_pop + {1'b0, inflight_q};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_sync) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      skid_cnt_q <= skid_cnt_d;
    end
  end

  // Skid data needs no reset; skid_cnt qualifies it.
  always_ff @(posedge i_clk) begin
    skid_q <= skid_d;
  end
endmodule
